// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types (parity modes, receiver FSM states)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : synchronous FIFO with first-word fall-through read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rcv_cfg.sv
// ---------------------------------------------------------------------------
// uart_rcv_cfg : configurable UART receiver with error flags and RX FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rcv_cfg
  import uart_pkg::*;
#(
  parameter int      CLK_DIV    = 43,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 rdy,
  output logic                 ovr_err
);

  localparam int                CW        = $clog2(CLK_DIV);
  localparam int                BW        = $clog2(DATA_BITS + 1);
  localparam int                FW        = DATA_BITS + 2;
  localparam logic [CW-1:0]     TC_HALF   = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]     TC_FULL   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0]     LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]     LAST_STOP = BW'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;
  logic                 frm_flag;
  logic                 par_calc;
  logic                 tc;
  logic                 push;
  logic [FW-1:0]        push_data;
  logic [FW-1:0]        head;
  logic                 full;
  logic                 empty;

  // Both flops reset high so an idle line never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  assign tc       = (state == START) ? (baud_cnt == TC_HALF) : (baud_cnt == TC_FULL);
  assign par_calc = (PARITY == PAR_ODD) ? ~^{shreg, rx_sync} : ^{shreg, rx_sync};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = {frm_flag | ~rx_sync, par_flag, shreg};
    case (state)
      IDLE:  if (!rx_sync) state_nxt = START;
      START: if (tc) state_nxt = rx_sync ? IDLE : DATA;
      DATA:  if (tc && (bit_cnt == LAST_DATA))
               state_nxt = (PARITY == PAR_NONE) ? STOP : PAR;
      PAR:   if (tc) state_nxt = STOP;
      STOP:  if (tc && (bit_cnt == LAST_STOP)) begin
               push      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else begin
      if ((state == IDLE) || (state_nxt != state) || tc) baud_cnt <= '0;
      else                                               baud_cnt <= baud_cnt + 1'b1;

      if (state_nxt != state)                            bit_cnt <= '0;
      else if (tc && ((state == DATA) || (state == STOP))) bit_cnt <= bit_cnt + 1'b1;

      if ((state == DATA) && tc) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};

      if (state == START) begin
        par_flag <= 1'b0;
        frm_flag <= 1'b0;
      end
      if ((state == PAR) && tc)  par_flag <= par_calc;
      if ((state == STOP) && tc) frm_flag <= frm_flag | ~rx_sync;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .din   (push_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A simultaneous pop makes room, so only an unserviced full push is an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n)                        ovr_err <= 1'b0;
    else if (push && full && !rd_en)   ovr_err <= 1'b1;
    else if (clr_err)                  ovr_err <= 1'b0;
  end

  assign rdy     = !empty;
  assign rx_data = rdy ? head[DATA_BITS-1:0] : '0;
  assign par_err = rdy & head[DATA_BITS];
  assign frm_err = rdy & head[DATA_BITS+1];

endmodule

`default_nettype wire

// File: tb/tb_uart_rcv_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rcv_cfg : scoreboard bench for 8N1 and 7E2 receiver instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rcv_cfg;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, rd0, rd1, clr0, clr1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       pe0, fe0, rdy0, ovr0, pe1, fe1, rdy1, ovr1;
  bit         pop_en0 = 1'b0;
  bit         pop_en1 = 1'b0;
  exp_t       q0[$];
  exp_t       q1[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_rcv_cfg #(
    .CLK_DIV(43), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .rd_en(rd0), .clr_err(clr0),
    .rx_data(data0), .par_err(pe0), .frm_err(fe0), .rdy(rdy0), .ovr_err(ovr0)
  );

  uart_rcv_cfg #(
    .CLK_DIV(16), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .rd_en(rd1), .clr_err(clr1),
    .rx_data(data1), .par_err(pe1), .frm_err(fe1), .rdy(rdy1), .ovr_err(ovr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop whenever a head is presented and popping is enabled.
  initial begin
    rd0 = 1'b0;
    forever begin
      exp_t e;
      @(negedge clk);
      rd0 = 1'b0;
      if (rdy0 && pop_en0) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mon0_unexpected: got data 0x%0h expected no entry", data0);
        end else begin
          e = q0.pop_front();
          check("mon0_data", 32'(data0), 32'(e.d));
          check("mon0_par",  32'(pe0),   32'(e.p));
          check("mon0_frm",  32'(fe0),   32'(e.f));
        end
        rd0 = 1'b1;
      end
    end
  end

  initial begin
    rd1 = 1'b0;
    forever begin
      exp_t e;
      @(negedge clk);
      rd1 = 1'b0;
      if (rdy1 && pop_en1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mon1_unexpected: got data 0x%0h expected no entry", data1);
        end else begin
          e = q1.pop_front();
          check("mon1_data", 32'({1'b0, data1}), 32'(e.d));
          check("mon1_par",  32'(pe1),           32'(e.p));
          check("mon1_frm",  32'(fe1),           32'(e.f));
        end
        rd1 = 1'b1;
      end
    end
  end

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) begin
      rx0 = v;
      repeat (43) @(posedge clk);
    end else begin
      rx1 = v;
      repeat (16) @(posedge clk);
    end
  endtask

  task automatic send(input int which, input int nbits, input logic [7:0] d,
                      input bit has_par, input logic pbit, input int nstop,
                      input logic last_stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(which, (i == nstop - 1) ? last_stop : 1'b1);
  endtask

  task automatic wait_drain(input int which, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (((which == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    check($sformatf("drain%0d_left", which),
          32'((which == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy0",  32'(rdy0),  32'd0);
    check("rst_data0", 32'(data0), 32'd0);
    check("rst_par0",  32'(pe0),   32'd0);
    check("rst_frm0",  32'(fe0),   32'd0);
    check("rst_ovr0",  32'(ovr0),  32'd0);
    check("rst_rdy1",  32'(rdy1),  32'd0);
    check("rst_state0", 32'(dut0.state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 8N1 single frame
    pop_en0 = 1'b1;
    q0.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
    send(0, 8, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(0, 200);
    repeat (4) @(negedge clk);
    check("a5_rdy_after_pop", 32'(rdy0), 32'd0);

    // Start-bit glitch
    rx0 = 1'b0;
    repeat (10) @(posedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_state", 32'(dut0.state), 32'(IDLE));
    check("glitch_rdy",   32'(rdy0),       32'd0);

    // 7E2: parity error, clean, framing error, then clean
    pop_en1 = 1'b1;
    q1.push_back('{d: 8'h3C, p: 1'b1, f: 1'b0});
    q1.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0});
    q1.push_back('{d: 8'h55, p: 1'b0, f: 1'b1});
    q1.push_back('{d: 8'h2A, p: 1'b0, f: 1'b0});
    send(1, 7, 8'h3C, 1'b1, 1'b1, 2, 1'b1);
    send(1, 7, 8'h3C, 1'b1, 1'b0, 2, 1'b1);
    send(1, 7, 8'h55, 1'b1, 1'b0, 2, 1'b0);
    drive_bit(1, 1'b1);
    send(1, 7, 8'h2A, 1'b1, 1'b1, 2, 1'b1);
    wait_drain(1, 200);
    repeat (4) @(negedge clk);
    check("b_rdy_after_pop", 32'(rdy1), 32'd0);
    check("b_ovr",           32'(ovr1), 32'd0);

    // Overrun: five frames into a four-entry FIFO
    pop_en0 = 1'b0;
    for (int k = 1; k <= 4; k++) q0.push_back('{d: 8'(k), p: 1'b0, f: 1'b0});
    for (int k = 1; k <= 5; k++) send(0, 8, 8'(k), 1'b0, 1'b0, 1, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_set",   32'(ovr0),  32'd1);
    check("ovr_rdy",   32'(rdy0),  32'd1);
    check("ovr_head",  32'(data0), 32'h01);
    pop_en0 = 1'b1;
    wait_drain(0, 400);
    repeat (4) @(negedge clk);
    check("ovr_rdy_empty", 32'(rdy0), 32'd0);
    check("ovr_sticky",    32'(ovr0), 32'd1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("ovr_cleared", 32'(ovr0), 32'd0);

    // Reset mid data bit 3 with a stale entry in the FIFO
    pop_en0 = 1'b0;
    send(0, 8, 8'h77, 1'b0, 1'b0, 1, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_rst_rdy", 32'(rdy0), 32'd1);
    partial = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, partial[i]);
    rx0 = partial[3];
    repeat (20) @(posedge clk);
    rst_n = 1'b0;
    rx0   = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_rdy",   32'(rdy0),  32'd0);
    check("mid_rst_data",  32'(data0), 32'd0);
    check("mid_rst_par",   32'(pe0),   32'd0);
    check("mid_rst_frm",   32'(fe0),   32'd0);
    check("mid_rst_ovr",   32'(ovr0),  32'd0);
    check("mid_rst_state", 32'(dut0.state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    pop_en0 = 1'b1;
    q0.push_back('{d: 8'hC3, p: 1'b0, f: 1'b0});
    send(0, 8, 8'hC3, 1'b0, 1'b0, 1, 1'b1);
    wait_drain(0, 200);
    repeat (4) @(negedge clk);
    check("c3_rdy_after_pop", 32'(rdy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
